// File: rtl/queue_query_engine.sv
// Bounded circular-buffer model of an int queue that answers array query functions on its live contents.
// One-cycle command-to-response latency; a held response (rsp_ready=0) stalls cmd_ready until consumed.
module queue_query_engine #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [2:0]               cmd_qsel,
  input  logic [31:0]              cmd_dim,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] W32 = 32'(WIDTH);

  localparam logic [2:0] OP_PUSH_BACK  = 3'd0;
  localparam logic [2:0] OP_PUSH_FRONT = 3'd1;
  localparam logic [2:0] OP_POP_BACK   = 3'd2;
  localparam logic [2:0] OP_POP_FRONT  = 3'd3;
  localparam logic [2:0] OP_READ       = 3'd4;
  localparam logic [2:0] OP_CLEAR      = 3'd5;
  localparam logic [2:0] OP_QUERY      = 3'd6;

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;

  logic             accept;
  logic [AW-1:0]    cnt_lo;
  logic [AW-1:0]    tail_idx;
  logic [AW-1:0]    back_idx;
  logic [AW-1:0]    front_idx;
  logic [AW-1:0]    rd_idx;
  logic [31:0]      data_ext;
  logic [31:0]      n32;
  logic [31:0]      nm1;
  logic [31:0]      q_res;
  logic             q_err;
  logic [31:0]      nxt_data;
  logic             nxt_err;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    nxt_head;
  logic [CW-1:0]    nxt_count;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign rsp_valid = (state == RESP);
  assign cmd_ready = !rsp_valid || rsp_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));

  assign cnt_lo    = count[AW-1:0];
  assign tail_idx  = head + cnt_lo;
  assign back_idx  = head + cnt_lo - AW'(1);
  assign front_idx = head - AW'(1);
  assign rd_idx    = head + data_ext[AW-1:0];
  assign n32       = 32'(count);
  assign nm1       = n32 - 32'd1;

  always_comb begin
    data_ext = '0;
    data_ext[WIDTH-1:0] = cmd_data;
  end

  // Dimension 1 is the queue itself (ascending, [0:n-1]); dimension 2 is the packed element range.
  always_comb begin
    q_res = '0;
    q_err = 1'b0;
    if (cmd_qsel == 3'd6) begin
      q_res = 32'd2;
    end else if (cmd_qsel == 3'd7) begin
      q_res = 32'd1;
    end else if (cmd_dim == 32'd1) begin
      case (cmd_qsel)
        3'd1:    q_res = nm1;
        3'd3:    q_res = nm1;
        3'd4:    q_res = n32;
        3'd5:    q_res = (count <= CW'(1)) ? 32'd1 : 32'hFFFF_FFFF;
        default: q_res = '0;
      endcase
    end else if (cmd_dim == 32'd2) begin
      case (cmd_qsel)
        3'd1:    q_res = W32 - 32'd1;
        3'd2:    q_res = W32 - 32'd1;
        3'd4:    q_res = W32;
        3'd5:    q_res = 32'd1;
        default: q_res = '0;
      endcase
    end else begin
      q_err = 1'b1;
    end
  end

  always_comb begin
    nxt_data  = '0;
    nxt_err   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = tail_idx;
    nxt_head  = head;
    nxt_count = count;
    case (cmd_op)
      OP_PUSH_BACK, OP_PUSH_FRONT: begin
        if (full) begin
          nxt_err = 1'b1;
        end else begin
          wr_en     = 1'b1;
          nxt_count = count + CW'(1);
          nxt_data  = 32'(count + CW'(1));
          if (cmd_op == OP_PUSH_FRONT) begin
            wr_idx   = front_idx;
            nxt_head = front_idx;
          end
        end
      end
      OP_POP_BACK: begin
        if (empty) begin
          nxt_err = 1'b1;
        end else begin
          nxt_count = count - CW'(1);
          nxt_data  = zext(mem[back_idx]);
        end
      end
      OP_POP_FRONT: begin
        if (empty) begin
          nxt_err = 1'b1;
        end else begin
          nxt_count = count - CW'(1);
          nxt_head  = head + AW'(1);
          nxt_data  = zext(mem[head]);
        end
      end
      OP_READ: begin
        if (data_ext >= n32) nxt_err = 1'b1;
        else                 nxt_data = zext(mem[rd_idx]);
      end
      OP_CLEAR: begin
        nxt_head  = '0;
        nxt_count = '0;
      end
      OP_QUERY: begin
        nxt_err  = q_err;
        nxt_data = q_err ? 32'd0 : q_res;
      end
      default: nxt_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      head     <= '0;
      count    <= '0;
    end else if (accept) begin
      state    <= RESP;
      rsp_data <= nxt_data;
      rsp_err  <= nxt_err;
      head     <= nxt_head;
      count    <= nxt_count;
    end else if (rsp_ready) begin
      state    <= IDLE;
    end
  end

  // Storage is deliberately left unreset; only head/count define validity.
  always_ff @(posedge clk) begin
    if (accept && wr_en && !rst) mem[wr_idx] <= cmd_data;
  end

endmodule

// File: doc/queue_query_engine.md
# queue_query_engine

Bounded queue store that models an `int q[$]` variable and answers array query system functions (`$low`, `$high`, `$left`, `$right`, `$size`, `$increment`, `$dimensions`, `$unpacked_dimensions`) against its live contents. It sits upstream of the query-function checker: it builds and mutates the queue that the checker inspects, and returns reference results the checker compares against. Commands and responses use valid/ready handshakes, with a single-entry response register.

## Interface
Parameters:
- DEPTH, 8, queue capacity; must be a power of 2 and ≥ 2.
- WIDTH, 32, element width; range 1..32. Elements are zero-extended onto rsp_data.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_op  in  3  operation code:
  - 0 PUSH_BACK, 1 PUSH_FRONT, 2 POP_BACK, 3 POP_FRONT
  - 4 READ, 5 CLEAR, 6 QUERY, 7 reserved
- cmd_data  in  WIDTH  push value, or element index for READ.
- cmd_qsel  in  3  query select:
  - 0 LOW, 1 HIGH, 2 LEFT, 3 RIGHT
  - 4 SIZE, 5 INCREMENT, 6 DIMENSIONS, 7 UNPACKED_DIMENSIONS
- cmd_dim  in  32  dimension argument for qsel 0–5.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  signed two's-complement result.
- rsp_err  out  1  command failed; rsp_data is 0 when set.
- count  out  $clog2(DEPTH)+1  current element count.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Storage is a circular buffer: head pointer plus count. Element i is at mem[(head+i) mod DEPTH].
- PUSH_FRONT decrements head modulo DEPTH. POP_FRONT increments it.
- Response FSM has two states, IDLE and RESP.
  - IDLE → RESP on command accept.
  - RESP → IDLE on rsp_ready, unless a new command is accepted in the same cycle; then it stays in RESP.
- Every accepted command produces exactly one response:
  - PUSH_*: rsp_data = new count. When full, rsp_err=1 and the queue is unchanged.
  - POP_*: rsp_data = removed element. When empty, rsp_err=1 and the queue is unchanged.
  - READ: rsp_data = element[cmd_data]. If cmd_data ≥ count, rsp_err=1.
  - CLEAR: count←0, head←0, rsp_data = 0.
  - Op 7: rsp_err=1, no state change.
- QUERY with dim 1 (the queue dimension), n = count:
  - LOW=0, HIGH=n−1, LEFT=0, RIGHT=n−1, SIZE=n.
  - INCREMENT = 1 if LEFT ≥ RIGHT, else −1. So n=0 gives HIGH=RIGHT=−1 and INCREMENT=1; n=1 gives INCREMENT=1.
- QUERY with dim 2 (the element's packed range [WIDTH−1:0]):
  - LOW=0, HIGH=WIDTH−1, LEFT=WIDTH−1, RIGHT=0, SIZE=WIDTH, INCREMENT=1.
- QUERY with any other cmd_dim (0, ≥3, or negative) for qsel 0–5: rsp_err=1.
- DIMENSIONS returns 2 and UNPACKED_DIMENSIONS returns 1; both ignore cmd_dim.
- All results are computed as 32-bit signed values. n−1 is sign-correct at n=0.

## Timing
- cmd_ready = !rsp_valid || rsp_ready. It is combinational, and is 1 during and after reset.
- Latency: a command accepted in cycle t has rsp_valid high from cycle t+1.
  - Queue state, count, empty and full update at the same edge.
- Back-to-back throughput is one command per cycle while rsp_ready is held at 1.
- rsp_data and rsp_err hold stable while rsp_valid=1 and rsp_ready=0.
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - count=0, head=0, empty=1, full=0.
  - mem contents are not reset.
- Reset mid-operation: a pending response is dropped and the queue empties immediately (asynchronously). The first command after reset deassertion is accepted normally.
- A QUERY issued immediately after a push or pop sees the updated count. Commands are strictly serialized.

## Test plan
- Reset, then QUERY SIZE/HIGH/RIGHT/INCREMENT dim 1 → 0, −1, −1, 1, with rsp_err=0.
- PUSH_BACK 10, 20, 30 back-to-back with rsp_ready=1 → responses 1, 2, 3.
  - Then QUERY LOW/HIGH/LEFT/RIGHT/SIZE/INCREMENT → 0, 2, 0, 2, 3, −1.
  - Then READ 1 → 20.
- PUSH_FRONT 5 on [10,20,30] → 4.
  - Then READ 0 → 5, POP_BACK → 30, POP_FRONT → 5, SIZE → 2.
- Fill to DEPTH=8 → full=1. A ninth push → rsp_err=1 with count still 8.
  - Then CLEAR, then POP_FRONT → rsp_err=1.
  - Repeat front/back push/pop 20 times to exercise head wrap-around; the FIFO order is preserved.
- QUERY dim 2 with WIDTH=32 → LEFT=31, RIGHT=0, SIZE=32, INCREMENT=1.
  - DIMENSIONS → 2, UNPACKED_DIMENSIONS → 1.
  - dim 3 → rsp_err=1, rsp_data=0.
- Hold rsp_ready=0 for 5 cycles after a push → cmd_ready=0 and the response stays stable.
  - Assert rst mid-stall → rsp_valid=0 and count=0 immediately.
